// File: rtl/snake_grid_renderer.sv
// Tile-grid snake overlay: segment list -> double-buffered occupancy bitmap -> 2-stage pixel colouring.
// Optional head highlight tile when SNAKE_HEAD_EN is defined.
module snake_grid_renderer #(
  parameter int          GRID_COLS   = 10,
  parameter int          GRID_ROWS   = 10,
  parameter int          TILE_SIZE   = 40,
  parameter int          ORIGIN_X    = 48,
  parameter int          ORIGIN_Y    = 48,
  parameter int          MAX_SEGS    = 100,
  parameter logic [11:0] SNAKE_COLOR = 12'h080,
  parameter logic [11:0] HEAD_COLOR  = 12'h0F0,
  localparam int         CW          = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1,
  localparam int         RW          = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1,
  localparam int         SCW         = $clog2(MAX_SEGS + 1)
) (
  input  logic           clk25,
  input  logic           reset,
  input  logic           screenEnd,
  input  logic           active,
  input  logic [9:0]     x,
  input  logic [9:0]     y,
  input  logic [11:0]    bg_color,
  input  logic           game_done,
  input  logic           seg_valid,
  output logic           seg_ready,
  input  logic [CW-1:0]  seg_col,
  input  logic [RW-1:0]  seg_row,
  input  logic           seg_last,
  output logic [11:0]    pix_color,
  output logic           pix_active,
  output logic           pix_hit,
  output logic [SCW-1:0] seg_count,
  output logic           frame_overflow
);

  localparam int          NCELLS  = GRID_COLS * GRID_ROWS;
  localparam logic [10:0] OX      = 11'(ORIGIN_X);
  localparam logic [10:0] OY      = 11'(ORIGIN_Y);
  localparam logic [10:0] X_END   = 11'(ORIGIN_X + GRID_COLS * TILE_SIZE);
  localparam logic [10:0] Y_END   = 11'(ORIGIN_Y + GRID_ROWS * TILE_SIZE);
  localparam logic [10:0] TS_M1   = 11'(TILE_SIZE - 1);
  localparam logic [CW:0] COLS_L  = GRID_COLS[CW:0];
  localparam logic [RW:0] ROWS_L  = GRID_ROWS[RW:0];
  localparam logic [SCW-1:0] MAX_L = MAX_SEGS[SCW-1:0];
  localparam logic [NCELLS-1:0] CELL0 = NCELLS'(1);

  typedef enum logic [1:0] {ST_CLEAR, ST_LOAD, ST_DONE} state_t;

  function automatic int unsigned tile_idx(input int unsigned col, input int unsigned row);
    return row * GRID_COLS + col;
  endfunction

  state_t            state, state_nxt;
  logic [NCELLS-1:0] back, back_nxt, front;
  logic              accept, in_range, write_ok, drop, swap;
  int unsigned       seg_idx;

  assign accept   = (state == ST_LOAD) && seg_valid;
  assign in_range = ({1'b0, seg_col} < COLS_L) && ({1'b0, seg_row} < ROWS_L);
  assign write_ok = accept && in_range && (seg_count != MAX_L);
  assign drop     = accept && !write_ok;
  // A swap either closes a finished list or coincides with the list's last beat.
  assign swap     = screenEnd && !game_done && ((state == ST_DONE) || (accept && seg_last));
  assign seg_idx  = tile_idx(32'(seg_col), 32'(seg_row));
  assign back_nxt = back | (write_ok ? (CELL0 << seg_idx) : '0);

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) state <= ST_CLEAR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    seg_ready = 1'b0;
    case (state)
      ST_CLEAR: state_nxt = ST_LOAD;
      ST_LOAD: begin
        seg_ready = 1'b1;
        if (seg_valid && seg_last) state_nxt = swap ? ST_CLEAR : ST_DONE;
      end
      ST_DONE: if (swap) state_nxt = ST_CLEAR;
      default: state_nxt = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      back           <= '0;
      front          <= '0;
      seg_count      <= '0;
      frame_overflow <= 1'b0;
    end else begin
      if (state == ST_CLEAR) begin
        back           <= '0;
        seg_count      <= '0;
        frame_overflow <= 1'b0;
      end else begin
        back <= back_nxt;
        if (write_ok) seg_count <= seg_count + SCW'(1);
        if (drop) frame_overflow <= 1'b1;
      end
      if (swap) front <= back_nxt;
    end
  end

  logic [10:0] x11, y11;
  logic [10:0] col_q, subx_q, row_q, suby_q;
  logic [10:0] col_cur, subx_cur, row_cur, suby_cur;
  logic        in_board, occ_s1, is_head_s1;
  int unsigned pix_idx;

  assign x11 = {1'b0, x};
  assign y11 = {1'b0, y};

`ifdef SNAKE_HEAD_EN
  logic          first_beat, hb_vld, hb_vld_nxt, hf_vld;
  logic [CW-1:0] hb_col, hb_col_nxt, hf_col;
  logic [RW-1:0] hb_row, hb_row_nxt, hf_row;

  always_comb begin
    hb_vld_nxt = hb_vld;
    hb_col_nxt = hb_col;
    hb_row_nxt = hb_row;
    if (accept && first_beat) begin
      hb_vld_nxt = write_ok;
      hb_col_nxt = seg_col;
      hb_row_nxt = seg_row;
    end
  end

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      first_beat <= 1'b1;
      hb_vld     <= 1'b0;
      hb_col     <= '0;
      hb_row     <= '0;
      hf_vld     <= 1'b0;
      hf_col     <= '0;
      hf_row     <= '0;
    end else begin
      if (state == ST_CLEAR) begin
        first_beat <= 1'b1;
        hb_vld     <= 1'b0;
      end else begin
        if (accept) first_beat <= 1'b0;
        hb_vld <= hb_vld_nxt;
        hb_col <= hb_col_nxt;
        hb_row <= hb_row_nxt;
      end
      if (swap) begin
        hf_vld <= hb_vld_nxt;
        hf_col <= hb_col_nxt;
        hf_row <= hb_row_nxt;
      end
    end
  end

  assign is_head_s1 = hf_vld && (col_cur == 11'(hf_col)) && (row_cur == 11'(hf_row));
`else
  assign is_head_s1 = 1'b0;
`endif

  // ---- S1: tile position tracking and front-bitmap lookup ----
  always_comb begin
    col_cur  = col_q;
    subx_cur = subx_q;
    row_cur  = row_q;
    suby_cur = suby_q;
    if (x11 == OX) begin
      col_cur  = '0;
      subx_cur = '0;
    end else if (subx_q == TS_M1) begin
      subx_cur = '0;
      col_cur  = col_q + 11'd1;
    end else begin
      subx_cur = subx_q + 11'd1;
    end
    // Rows advance once per line, on the board's left-edge pixel.
    if (x11 == OX) begin
      if (y11 == OY) begin
        row_cur  = '0;
        suby_cur = '0;
      end else if (y11 > OY) begin
        if (suby_q == TS_M1) begin
          suby_cur = '0;
          row_cur  = row_q + 11'd1;
        end else begin
          suby_cur = suby_q + 11'd1;
        end
      end
    end
  end

  assign in_board = (x11 >= OX) && (x11 < X_END) && (y11 >= OY) && (y11 < Y_END);
  assign pix_idx  = tile_idx(32'(col_cur), 32'(row_cur));
  assign occ_s1   = in_board && (|(front & (CELL0 << pix_idx)));

  always_ff @(posedge clk25) begin
    col_q  <= col_cur;
    subx_q <= subx_cur;
    row_q  <= row_cur;
    suby_q <= suby_cur;
  end

  logic vld_p1, occ_p1, head_p1;
  logic vld_p2, hit_p2;
  logic [11:0] color_p2;

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      occ_p1  <= 1'b0;
      head_p1 <= 1'b0;
    end else begin
      vld_p1  <= active;
      occ_p1  <= occ_s1;
      head_p1 <= occ_s1 && is_head_s1;
    end
  end

  // ---- S2: colour select against the aligned background ----
  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      vld_p2   <= 1'b0;
      hit_p2   <= 1'b0;
      color_p2 <= '0;
    end else begin
      vld_p2 <= vld_p1;
      hit_p2 <= occ_p1;
      if (!vld_p1)      color_p2 <= '0;
      else if (occ_p1)  color_p2 <= head_p1 ? HEAD_COLOR : SNAKE_COLOR;
      else              color_p2 <= bg_color;
    end
  end

  assign pix_active = vld_p2;
  assign pix_hit    = hit_p2;
  assign pix_color  = color_p2;

endmodule

// File: tb/tb_snake_grid_renderer.sv
// Scoreboard bench for snake_grid_renderer: independent bitmap/geometry model, pixels checked 2 cycles later.
module tb_snake_grid_renderer;

  localparam logic [11:0] BG = 12'h123;

  logic        clk25 = 1'b0;
  logic        reset, screenEnd, active, game_done, seg_valid, seg_last;
  logic [9:0]  x, y;
  logic [11:0] bg_color;
  logic [3:0]  seg_col, seg_row;
  logic        seg_ready, pix_active, pix_hit, frame_overflow;
  logic [11:0] pix_color;
  logic [6:0]  seg_count;

  snake_grid_renderer dut (
    .clk25(clk25), .reset(reset), .screenEnd(screenEnd), .active(active),
    .x(x), .y(y), .bg_color(bg_color), .game_done(game_done),
    .seg_valid(seg_valid), .seg_ready(seg_ready), .seg_col(seg_col), .seg_row(seg_row),
    .seg_last(seg_last), .pix_color(pix_color), .pix_active(pix_active), .pix_hit(pix_hit),
    .seg_count(seg_count), .frame_overflow(frame_overflow)
  );

  always #20 clk25 = ~clk25;

  int cyc = 0;
  always @(posedge clk25) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          cyc;
    int          px;
    int          py;
    logic        act;
    logic        hit;
    logic [11:0] color;
  } exp_t;
  exp_t sb[$];

  bit exp_front[100];
  bit exp_back[100];
  int exp_cnt;
  bit exp_ovf;
  bit first;
  bit hb_vld, hf_vld;
  int hb_c, hb_r, hf_c, hf_r;

  function automatic bit model_hit(input int px, input int py);
    if (px < 48 || px >= 448 || py < 48 || py >= 448) return 1'b0;
    return exp_front[((py - 48) / 40) * 10 + (px - 48) / 40];
  endfunction

  function automatic logic [11:0] model_color(input int px, input int py);
    if (!model_hit(px, py)) return BG;
`ifdef SNAKE_HEAD_EN
    if (hf_vld && ((px - 48) / 40) == hf_c && ((py - 48) / 40) == hf_r) return 12'h0F0;
`endif
    return 12'h080;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 100; i++) exp_back[i] = 1'b0;
    exp_cnt = 0;
    exp_ovf = 1'b0;
    first   = 1'b1;
    hb_vld  = 1'b0;
  endtask

  task automatic model_accept(input int c, input int r);
    bit inr;
    inr = (c < 10) && (r < 10);
    if (first) begin
      first  = 1'b0;
      hb_vld = inr;
      hb_c   = c;
      hb_r   = r;
    end
    if (inr && exp_cnt < 100) begin
      exp_back[r * 10 + c] = 1'b1;
      exp_cnt++;
    end else begin
      exp_ovf = 1'b1;
    end
  endtask

  task automatic model_swap();
    for (int i = 0; i < 100; i++) exp_front[i] = exp_back[i];
    hf_vld = hb_vld;
    hf_c   = hb_c;
    hf_r   = hb_r;
    model_clear();
  endtask

  task tick();
    @(posedge clk25);
    #1;
  endtask

  // Pixel scoreboard: each entry is due two clock edges after it was driven.
  always @(negedge clk25) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc + 2 <= cyc) begin
      e = sb.pop_front();
      n_checks++;
      if (e.cyc + 2 != cyc) begin
        n_fail++;
        $display("FAIL pixel_latency (%0d,%0d): popped at cycle %0d, required %0d", e.px, e.py, cyc, e.cyc + 2);
      end else if (pix_color !== e.color || pix_hit !== e.hit || pix_active !== e.act) begin
        n_fail++;
        $display("FAIL pixel (%0d,%0d): got color=%h hit=%b act=%b, want color=%h hit=%b act=%b",
                 e.px, e.py, pix_color, pix_hit, pix_active, e.color, e.hit, e.act);
      end
    end
  end

  task automatic send_beat(input int c, input int r, input bit last);
    bit ok;
    seg_col = 4'(c); seg_row = 4'(r); seg_last = last; seg_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk25);
      if (seg_ready === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) seg_valid = 1'b0;
    tick();
    seg_valid = 1'b0; seg_last = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL beat_handshake (%0d,%0d): seg_ready got %b, want 1 within 20 cycles", c, r, seg_ready);
    end else begin
      model_accept(c, r);
    end
  endtask

  task automatic pulse_screen(input bit gd, input bit expect_swap);
    screenEnd = 1'b1; game_done = gd;
    tick();
    screenEnd = 1'b0; game_done = 1'b0;
    if (expect_swap) model_swap();
  endtask

  task automatic scan_line(input int yv, input int x_hi);
    exp_t e;
    for (int yy = 48; yy < yv; yy++) begin
      x = 10'(48); y = 10'(yy); active = 1'b0;
      tick();
    end
    for (int xx = 44; xx <= x_hi; xx++) begin
      x = 10'(xx); y = 10'(yv); active = (xx != 60);
      e.cyc = cyc; e.px = xx; e.py = yv; e.act = active;
      e.hit = model_hit(xx, yv);
      e.color = active ? model_color(xx, yv) : 12'h000;
      sb.push_back(e);
      tick();
    end
    active = 1'b0; x = '0; y = '0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; screenEnd = 0; active = 0; game_done = 0; seg_valid = 0; seg_last = 0;
    x = '0; y = '0; bg_color = BG; seg_col = '0; seg_row = '0;
    repeat (3) tick();
    n_checks++; if (seg_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", seg_ready); end
    n_checks++; if (pix_color !== 12'h000) begin n_fail++; $display("FAIL rst_color: got %h want 000", pix_color); end
    n_checks++; if (pix_active !== 1'b0) begin n_fail++; $display("FAIL rst_active: got %b want 0", pix_active); end
    n_checks++; if (pix_hit !== 1'b0) begin n_fail++; $display("FAIL rst_hit: got %b want 0", pix_hit); end
    n_checks++; if (seg_count !== 7'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", seg_count); end
    n_checks++; if (frame_overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b want 0", frame_overflow); end
    reset = 1'b0;
    n_checks++; if (seg_ready !== 1'b0) begin n_fail++; $display("FAIL clear_ready: got %b want 0", seg_ready); end
    tick();
    n_checks++; if (seg_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready: got %b want 1", seg_ready); end
    for (int i = 0; i < 100; i++) exp_front[i] = 1'b0;
    hf_vld = 1'b0;
    model_clear();
  endtask

  task automatic test_reset_mid_load();
    send_beat(1, 1, 0);
    send_beat(2, 2, 0);
    send_beat(3, 3, 0);
    n_checks++; if (seg_count !== 7'd3) begin n_fail++; $display("FAIL midload_count: got %0d want 3", seg_count); end
    reset = 1'b1;
    #1;
    n_checks++; if (seg_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b want 0", seg_ready); end
    n_checks++; if (seg_count !== 7'd0) begin n_fail++; $display("FAIL midrst_count: got %0d want 0", seg_count); end
    n_checks++; if (pix_color !== 12'h000) begin n_fail++; $display("FAIL midrst_color: got %h want 000", pix_color); end
    tick(); tick();
    reset = 1'b0;
    n_checks++; if (seg_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_clear_ready: got %b want 0", seg_ready); end
    tick();
    n_checks++; if (seg_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_load_ready: got %b want 1", seg_ready); end
    for (int i = 0; i < 100; i++) exp_front[i] = 1'b0;
    hf_vld = 1'b0;
    model_clear();
    scan_line(88, 200);
  endtask

  task automatic test_render();
    send_beat(2, 3, 0);
    send_beat(3, 3, 1);
    n_checks++; if (seg_count !== 7'd2) begin n_fail++; $display("FAIL render_count: got %0d want 2", seg_count); end
    n_checks++; if (seg_ready !== 1'b0) begin n_fail++; $display("FAIL render_done_ready: got %b want 0", seg_ready); end
    pulse_screen(1'b0, 1'b1);
    scan_line(168, 260);
  endtask

  task automatic test_screenend_in_load();
    send_beat(5, 5, 0);
    pulse_screen(1'b0, 1'b0);
    n_checks++; if (seg_ready !== 1'b1) begin n_fail++; $display("FAIL load_continues_ready: got %b want 1", seg_ready); end
    n_checks++; if (seg_count !== 7'd1) begin n_fail++; $display("FAIL load_continues_count: got %0d want 1", seg_count); end
    scan_line(168, 260);
    send_beat(0, 0, 1);
    pulse_screen(1'b0, 1'b1);
    scan_line(48, 260);
    scan_line(248, 300);
  endtask

  task automatic test_overflow();
    send_beat(10, 0, 0);
    n_checks++; if (frame_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_range: got %b want 1", frame_overflow); end
    n_checks++; if (seg_count !== 7'd0) begin n_fail++; $display("FAIL ovf_range_count: got %0d want 0", seg_count); end
    for (int i = 0; i < 100; i++) send_beat(i % 10, i / 10, 0);
    send_beat(1, 1, 1);
    n_checks++; if (seg_count !== 7'd100) begin n_fail++; $display("FAIL ovf_count: got %0d want 100", seg_count); end
    n_checks++; if (frame_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", frame_overflow); end
    n_checks++; if (seg_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_last_honoured: got ready %b want 0", seg_ready); end
    pulse_screen(1'b0, 1'b1);
    tick();
    n_checks++; if (frame_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_cleared: got %b want 0", frame_overflow); end
    n_checks++; if (seg_count !== 7'd0) begin n_fail++; $display("FAIL ovf_count_cleared: got %0d want 0", seg_count); end
    n_checks++; if (seg_ready !== 1'b1) begin n_fail++; $display("FAIL ovf_reload_ready: got %b want 1", seg_ready); end
    scan_line(48, 460);
  endtask

  task automatic test_last_on_screenend();
    bit ok;
    ok = 1'b0;
    seg_col = 4'd7; seg_row = 4'd7; seg_last = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk25);
      if (seg_ready === 1'b1) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL last_swap_ready: got %b want 1", seg_ready); end
    seg_valid = ok; screenEnd = ok;
    tick();
    seg_valid = 1'b0; screenEnd = 1'b0; seg_last = 1'b0;
    if (ok) begin
      model_accept(7, 7);
      model_swap();
    end
    n_checks++; if (seg_ready !== 1'b0) begin n_fail++; $display("FAIL last_swap_clear: got ready %b want 0", seg_ready); end
    scan_line(328, 400);
    send_beat(1, 1, 1);
    pulse_screen(1'b1, 1'b0);
    n_checks++; if (seg_ready !== 1'b0) begin n_fail++; $display("FAIL frozen_done: got ready %b want 0", seg_ready); end
    n_checks++; if (seg_count !== 7'd1) begin n_fail++; $display("FAIL frozen_count: got %0d want 1", seg_count); end
    scan_line(328, 400);
    scan_line(88, 200);
    pulse_screen(1'b0, 1'b1);
    scan_line(88, 200);
  endtask

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reset_mid_load();
    test_render();
    test_screenend_in_load();
    test_overflow();
    test_last_on_screenend();
    repeat (4) tick();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
